// File: rtl/kalman_innovation_generator.sv
// Kalman predict-stage producer: constant-velocity prediction, innovation, estimator bundle and feedback capture.
// Optional innovation gating is built when KALMAN_INNOV_GATE_EN is defined.
module kalman_innovation_generator #(
  parameter int FXP_WIDTH = 16,
  parameter int FXP_FRAC  = 8,
  parameter int STATE_DIM = 4,
  parameter int ACC_WIDTH = 32,
  parameter logic signed [FXP_WIDTH-1:0] DT_Q    = 16'sd256,
  parameter logic signed [FXP_WIDTH-1:0] Q_NOISE = 16'sd16,
  parameter logic signed [FXP_WIDTH-1:0] P0      = 16'sd256,
  parameter logic signed [FXP_WIDTH-1:0] GATE_Q  = 16'sd1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [FXP_WIDTH-1:0]           meas_in,
  input  logic                           meas_valid,
  output logic                           meas_ready,
  output logic [FXP_WIDTH-1:0]           measurement_out,
  output logic [FXP_WIDTH-1:0]           innovation_out,
  output logic [STATE_DIM*FXP_WIDTH-1:0] state_vector_out,
  output logic [STATE_DIM*FXP_WIDTH-1:0] state_cov_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic [STATE_DIM*FXP_WIDTH-1:0] state_fb_in,
  input  logic [STATE_DIM*FXP_WIDTH-1:0] cov_fb_in,
  input  logic                           fb_valid,
  output logic                           fb_ready,
  output logic [15:0]                    meas_count,
  output logic                           gate_hit
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // a valid source holds its data stable until that edge, and ready never depends on valid.

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREDICT,
    S_INNOV,
    S_OUTPUT,
    S_WAIT_FB
  } state_t;

  localparam int KW = $clog2(STATE_DIM);
  localparam logic [KW-1:0] K_LAST = KW'(STATE_DIM - 1);
  localparam logic signed [FXP_WIDTH-1:0] FXP_MAX = {1'b0, {(FXP_WIDTH-1){1'b1}}};
  localparam logic signed [FXP_WIDTH-1:0] FXP_MIN = {1'b1, {(FXP_WIDTH-1){1'b0}}};

  state_t                      state;
  logic [KW-1:0]               k;
  logic signed [FXP_WIDTH-1:0] meas_q;
  logic signed [FXP_WIDTH-1:0] x_q  [STATE_DIM];
  logic signed [FXP_WIDTH-1:0] p_q  [STATE_DIM];
  logic signed [FXP_WIDTH-1:0] xp_q [STATE_DIM];
  logic signed [FXP_WIDTH-1:0] pp_q [STATE_DIM];

  logic [KW-1:0]               k_next_idx;
  logic signed [ACC_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] coupled;
  logic signed [ACC_WIDTH:0]   xp_sum;
  logic signed [FXP_WIDTH:0]   pp_sum;
  logic signed [FXP_WIDTH:0]   innov_wide;
  logic signed [FXP_WIDTH-1:0] xp_elem;
  logic signed [FXP_WIDTH-1:0] pp_elem;
  logic signed [FXP_WIDTH-1:0] innov_val;
`ifdef KALMAN_INNOV_GATE_EN
  logic                        gate_clamp;
`endif

  function automatic logic signed [FXP_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] v);
    if (v > (ACC_WIDTH+1)'(FXP_MAX)) return FXP_MAX;
    if (v < (ACC_WIDTH+1)'(FXP_MIN)) return FXP_MIN;
    return v[FXP_WIDTH-1:0];
  endfunction

  // The last state element has no higher-order neighbour, so it passes through unchanged.
  always_comb begin
    k_next_idx = (k == K_LAST) ? k : k + KW'(1);
    prod       = ACC_WIDTH'(DT_Q) * ACC_WIDTH'(x_q[k_next_idx]);
    coupled    = prod >>> FXP_FRAC;
    xp_sum     = (ACC_WIDTH+1)'(x_q[k]) + (ACC_WIDTH+1)'(coupled);
    xp_elem    = (k == K_LAST) ? x_q[k] : sat_acc(xp_sum);
    pp_sum     = (FXP_WIDTH+1)'(p_q[k]) + (FXP_WIDTH+1)'(Q_NOISE);
    pp_elem    = sat_acc((ACC_WIDTH+1)'(pp_sum));
    innov_wide = (FXP_WIDTH+1)'(meas_q) - (FXP_WIDTH+1)'(xp_q[0]);
    innov_val  = sat_acc((ACC_WIDTH+1)'(innov_wide));
`ifdef KALMAN_INNOV_GATE_EN
    gate_clamp = 1'b0;
    if (innov_val > GATE_Q) begin
      innov_val  = GATE_Q;
      gate_clamp = 1'b1;
    end else if (innov_val < -GATE_Q) begin
      innov_val  = -GATE_Q;
      gate_clamp = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      k                <= '0;
      meas_q           <= '0;
      meas_ready       <= 1'b1;
      fb_ready         <= 1'b0;
      out_valid        <= 1'b0;
      measurement_out  <= '0;
      innovation_out   <= '0;
      state_vector_out <= '0;
      state_cov_out    <= '0;
      meas_count       <= '0;
      for (int j = 0; j < STATE_DIM; j++) begin
        x_q[j]  <= '0;
        p_q[j]  <= P0;
        xp_q[j] <= '0;
        pp_q[j] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (meas_valid && meas_ready) begin
            meas_q     <= meas_in;
            meas_count <= meas_count + 16'd1;
            k          <= '0;
            meas_ready <= 1'b0;
            state      <= S_PREDICT;
          end
        end
        S_PREDICT: begin
          xp_q[k] <= xp_elem;
          pp_q[k] <= pp_elem;
          if (k == K_LAST) state <= S_INNOV;
          else             k     <= k + KW'(1);
        end
        S_INNOV: begin
          measurement_out <= meas_q;
          innovation_out  <= innov_val;
          for (int j = 0; j < STATE_DIM; j++) begin
            state_vector_out[j*FXP_WIDTH +: FXP_WIDTH] <= xp_q[j];
            state_cov_out[j*FXP_WIDTH +: FXP_WIDTH]    <= pp_q[j];
          end
          out_valid <= 1'b1;
          state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fb_ready  <= 1'b1;
            state     <= S_WAIT_FB;
          end
        end
        S_WAIT_FB: begin
          if (fb_valid) begin
            for (int j = 0; j < STATE_DIM; j++) begin
              x_q[j] <= state_fb_in[j*FXP_WIDTH +: FXP_WIDTH];
              p_q[j] <= cov_fb_in[j*FXP_WIDTH +: FXP_WIDTH];
            end
            fb_ready   <= 1'b0;
            meas_ready <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef KALMAN_INNOV_GATE_EN
  logic gate_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              gate_q <= 1'b0;
    else if (state == S_INNOV)               gate_q <= gate_clamp;
    else if (state == S_OUTPUT && out_ready) gate_q <= 1'b0;
  end

  assign gate_hit = gate_q;
`else
  assign gate_hit = 1'b0;
`endif

endmodule

// File: tb/tb_kalman_innovation_generator.sv
// Randomized scoreboard bench for kalman_innovation_generator with a plain-arithmetic predict model.
module tb_kalman_innovation_generator;

  localparam int W = 16;
  localparam int N = 4;
  localparam int DT = 256;
  localparam int QN = 16;
  localparam int PINIT = 256;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   meas_in;
  logic           meas_valid;
  logic           meas_ready;
  logic [W-1:0]   measurement_out;
  logic [W-1:0]   innovation_out;
  logic [N*W-1:0] state_vector_out;
  logic [N*W-1:0] state_cov_out;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] state_fb_in;
  logic [N*W-1:0] cov_fb_in;
  logic           fb_valid;
  logic           fb_ready;
  logic [15:0]    meas_count;
  logic           gate_hit;

  kalman_innovation_generator dut (
    .clk(clk), .rst_n(rst_n),
    .meas_in(meas_in), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .measurement_out(measurement_out), .innovation_out(innovation_out),
    .state_vector_out(state_vector_out), .state_cov_out(state_cov_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .state_fb_in(state_fb_in), .cov_fb_in(cov_fb_in),
    .fb_valid(fb_valid), .fb_ready(fb_ready),
    .meas_count(meas_count), .gate_hit(gate_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   meas;
    logic [W-1:0]   innov;
    logic [N*W-1:0] sv;
    logic [N*W-1:0] cov;
    logic [15:0]    cnt;
    logic           gate;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mx[N];
  int   mp[N];
  int   mcnt;
  int   lat;
  logic [W-1:0]   snap_innov, snap_meas;
  logic [N*W-1:0] snap_sv, snap_cov;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < N; j++) begin
      mx[j] = 0;
      mp[j] = PINIT;
    end
    mcnt = 0;
  endfunction

  // Constant-velocity prediction from the held estimate, expressed directly in integers.
  function automatic exp_t model_predict(input logic [W-1:0] m);
    exp_t e;
    int xp[N];
    int innov;
    for (int j = 0; j < N; j++) begin
      if (j < N - 1) xp[j] = sat16(mx[j] + ((DT * mx[j+1]) >>> 8));
      else           xp[j] = mx[j];
      e.sv[j*W +: W]  = W'(xp[j]);
      e.cov[j*W +: W] = W'(sat16(mp[j] + QN));
    end
    innov  = sat16(int'($signed(m)) - xp[0]);
    e.gate = 1'b0;
`ifdef KALMAN_INNOV_GATE_EN
    if (innov > 1024)  begin innov = 1024;  e.gate = 1'b1; end
    if (innov < -1024) begin innov = -1024; e.gate = 1'b1; end
`endif
    e.innov = W'(innov);
    e.meas  = m;
    e.cnt   = 16'((mcnt + 1) & 16'hFFFF);
    return e;
  endfunction

  // Monitor: a bundle transfers on the next edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_bundle: got innovation %h with empty queue", innovation_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("bundle_meas",  64'(measurement_out),  64'(mon_e.meas));
        check("bundle_innov", 64'(innovation_out),   64'(mon_e.innov));
        check("bundle_state", 64'(state_vector_out), 64'(mon_e.sv));
        check("bundle_cov",   64'(state_cov_out),    64'(mon_e.cov));
        check("bundle_count", 64'(meas_count),       64'(mon_e.cnt));
        check("bundle_gate",  64'(gate_hit),         64'(mon_e.gate));
      end
    end
  end

  task automatic send_meas(input logic [W-1:0] m);
    @(negedge clk);
    meas_in    = m;
    meas_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (meas_ready) break;
      @(negedge clk);
    end
    if (!meas_ready) begin
      fail_timeout("meas_accept");
      meas_valid = 1'b0;
      return;
    end
    exp_q.push_back(model_predict(m));
    mcnt = (mcnt + 1) & 16'hFFFF;
    @(posedge clk);
    #1 meas_valid = 1'b0;
  endtask

  task automatic wait_valid(output int latency);
    latency = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        latency = c;
        return;
      end
    end
    fail_timeout("out_valid");
  endtask

  task automatic wait_done();
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (!out_valid) return;
    end
    fail_timeout("out_handshake");
  endtask

  task automatic do_fb(input logic [N*W-1:0] sv, input logic [N*W-1:0] cv);
    @(negedge clk);
    for (int c = 0; c < 100; c++) begin
      if (fb_ready) break;
      @(negedge clk);
    end
    if (!fb_ready) begin
      fail_timeout("fb_ready");
      return;
    end
    fb_valid    = 1'b1;
    state_fb_in = sv;
    cov_fb_in   = cv;
    @(posedge clk);
    #1 fb_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      mx[j] = int'($signed(sv[j*W +: W]));
      mp[j] = int'($signed(cv[j*W +: W]));
    end
    check("fb_ready_cleared", 64'(fb_ready),   64'd0);
    check("meas_ready_back",  64'(meas_ready), 64'd1);
  endtask

  task automatic run_txn(input logic [W-1:0] m, input int bp);
    int l;
    if (bp > 0) out_ready = 1'b0;
    send_meas(m);
    wait_valid(l);
    repeat (bp) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done();
  endtask

  task automatic check_reset_vals();
    check("rst_meas_ready", 64'(meas_ready),       64'd1);
    check("rst_fb_ready",   64'(fb_ready),         64'd0);
    check("rst_out_valid",  64'(out_valid),        64'd0);
    check("rst_meas_count", 64'(meas_count),       64'd0);
    check("rst_meas_out",   64'(measurement_out),  64'd0);
    check("rst_innov",      64'(innovation_out),   64'd0);
    check("rst_state",      64'(state_vector_out), 64'd0);
    check("rst_cov",        64'(state_cov_out),    64'd0);
    check("rst_gate",       64'(gate_hit),         64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; meas_in = '0; meas_valid = 1'b0; out_ready = 1'b1;
    state_fb_in = '0; cov_fb_in = '0; fb_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_vals();

    // Fresh reset: latency and initial predicted bundle.
    send_meas(16'h0200);
    wait_valid(lat);
    check("latency",       64'(lat),            64'd5);
    check("t1_innov",      64'(innovation_out), 64'h0200);
    check("t1_state",      state_vector_out,    64'h0);
    check("t1_cov",        state_cov_out,       64'h0110_0110_0110_0110);
    check("t1_count",      64'(meas_count),     64'd1);
    check("t1_meas_ready", 64'(meas_ready),     64'd0);
    wait_done();
    check("t1_fb_ready",   64'(fb_ready),       64'd1);
    do_fb(64'h0, {4{16'h0100}});

    // Backpressure: bundle frozen while out_ready is low.
    out_ready = 1'b0;
    send_meas(16'h0123);
    wait_valid(lat);
    snap_innov = innovation_out; snap_meas = measurement_out;
    snap_sv = state_vector_out;  snap_cov = state_cov_out;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_valid",      64'(out_valid),       64'd1);
      check("bp_innov",      64'(innovation_out),  64'(snap_innov));
      check("bp_meas",       64'(measurement_out), 64'(snap_meas));
      check("bp_state",      state_vector_out,     snap_sv);
      check("bp_cov",        state_cov_out,        snap_cov);
      check("bp_meas_ready", 64'(meas_ready),      64'd0);
      check("bp_fb_ready",   64'(fb_ready),        64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    check("bp_fb_ready_1", 64'(fb_ready),  64'd1);
    check("bp_bus_kept",   64'(innovation_out), 64'(snap_innov));
    do_fb({16'h0000, 16'h0000, 16'h0080, 16'h0100}, {4{16'h0100}});

    // Velocity coupling into position.
    send_meas(16'h0100);
    wait_valid(lat);
    check("t3_xp0",   64'(state_vector_out[15:0]),  64'h0180);
    check("t3_xp1",   64'(state_vector_out[31:16]), 64'h0080);
    check("t3_innov", 64'(innovation_out),          64'hFF80);
    check("t3_cov",   state_cov_out,                64'h0110_0110_0110_0110);
    wait_done();
    do_fb({16'h0000, 16'h0000, 16'h7F00, 16'h7F00}, {4{16'h7FF8}});

    // Saturation of prediction, covariance and innovation.
    send_meas(16'h8000);
    wait_valid(lat);
    check("t4_xp0", 64'(state_vector_out[15:0]), 64'h7FFF);
    check("t4_cov", state_cov_out,               64'h7FFF_7FFF_7FFF_7FFF);
`ifdef KALMAN_INNOV_GATE_EN
    check("t4_innov", 64'(innovation_out), 64'hFC00);
`else
    check("t4_innov", 64'(innovation_out), 64'h8000);
`endif
    wait_done();
    do_fb(64'h0, {4{16'h0100}});

    // Large innovation from a zero state, then a small one.
    send_meas(16'h0800);
    wait_valid(lat);
`ifdef KALMAN_INNOV_GATE_EN
    check("gate_innov", 64'(innovation_out), 64'h0400);
    check("gate_hit_1", 64'(gate_hit),       64'd1);
`else
    check("gate_innov", 64'(innovation_out), 64'h0800);
    check("gate_hit_0", 64'(gate_hit),       64'd0);
`endif
    wait_done();
    check("gate_clear", 64'(gate_hit), 64'd0);
    do_fb(64'h0, {4{16'h0100}});
    send_meas(16'h0100);
    wait_valid(lat);
    check("gate_small", 64'(gate_hit), 64'd0);
    wait_done();
    do_fb({16'h0010, 16'h0020, 16'h0030, 16'h0040}, {4{16'h0200}});

    // Reset in the middle of prediction discards the measurement.
    send_meas(16'(($urandom & 32'hFFFF)));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check_reset_vals();
    rst_n = 1'b1;
    exp_q.delete();
    model_reset();
    send_meas(16'h0040);
    wait_valid(lat);
    check("post_rst_innov", 64'(innovation_out), 64'h0040);
    check("post_rst_count", 64'(meas_count),     64'd1);
    wait_done();
    do_fb(64'h0, {4{16'h0100}});

    // Random traffic with random backpressure, feedback, and stray feedback pulses in IDLE.
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 0) begin
        @(negedge clk);
        fb_valid    = 1'b1;
        state_fb_in = {$urandom, $urandom};
        cov_fb_in   = {$urandom, $urandom};
        @(posedge clk);
        #1 fb_valid = 1'b0;
      end
      run_txn(16'($urandom & 32'hFFFF), int'($urandom_range(0, 3)));
      if (i % 2 == 0)
        do_fb({$urandom, $urandom}, {$urandom, $urandom});
      else
        do_fb({4{16'($urandom_range(0, 511))}}, {4{16'($urandom_range(0, 1023))}});
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kalman_innovation_generator.md
Name: kalman_innovation_generator

Overview:
Predict-stage producer that feeds the Kalman state estimator. It accepts raw measurements and propagates the held state and covariance through a constant-velocity transition model. It computes innovation = measurement − predicted measurement and presents measurement, innovation, predicted state and predicted covariance on the estimator's input bus. The corrected state and covariance come back from the estimator through a feedback handshake and become the held state for the next measurement.

Parameters:
- FXP_WIDTH, 16, signed fixed-point word width.
- FXP_FRAC, 8, fractional bits (Q8.8).
- STATE_DIM, 4, state elements; must be ≥2.
- ACC_WIDTH, 32, product/accumulator width.
- DT_Q, 16'sd256, transition coupling dt in Q8.8 (1.0).
- Q_NOISE, 16'sd16, process noise added to each covariance element (0.0625).
- P0, 16'sd256, covariance reset/init value per element (1.0).
- GATE_Q, 16'sd1024, innovation gate magnitude (4.0); used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- meas_in  in  FXP_WIDTH  signed measurement.
- meas_valid  in  1  measurement valid.
- meas_ready  out  1  measurement accepted when high with meas_valid.
- measurement_out  out  FXP_WIDTH  latched measurement to estimator.
- innovation_out  out  FXP_WIDTH  signed innovation.
- state_vector_out  out  STATE_DIM*FXP_WIDTH  predicted state; element j at [(j+1)*FXP_WIDTH-1 -: FXP_WIDTH].
- state_cov_out  out  STATE_DIM*FXP_WIDTH  predicted covariance; same packing.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  estimator accepts bundle.
- state_fb_in  in  STATE_DIM*FXP_WIDTH  corrected state from estimator.
- cov_fb_in  in  STATE_DIM*FXP_WIDTH  corrected covariance from estimator.
- fb_valid  in  1  feedback valid.
- fb_ready  out  1  feedback accepted when high with fb_valid.
- meas_count  out  16  accepted-measurement counter; wraps at 0xFFFF→0.
- gate_hit  out  1  innovation was clamped; driven 0 when the feature is absent.

Behaviour:
- Reset values:
  - All outputs 0, except meas_ready=1 and fb_ready=0.
  - Held state x[] = 0; held covariance P[] = P0; FSM = IDLE; index k = 0.
- FSM states: IDLE → PREDICT → INNOV → OUTPUT → WAIT_FB → IDLE.
- IDLE:
  - meas_ready=1.
  - On meas_valid & meas_ready: latch meas_in, increment meas_count, set k=0, go to PREDICT.
- PREDICT (STATE_DIM cycles):
  - One element per cycle, written to separate pred registers; x[] and P[] are not modified.
  - For k < STATE_DIM-1: xp[k] = sat(x[k] + ((DT_Q*x[k+1]) >>> FXP_FRAC)), product in ACC_WIDTH.
  - For k = STATE_DIM-1: xp[k] = x[k].
  - pp[k] = sat(P[k] + Q_NOISE).
  - k increments each cycle; after k = STATE_DIM-1, go to INNOV.
- INNOV (1 cycle):
  - innovation = sat(meas − xp[0]), computed at FXP_WIDTH+1 bits.
  - Load all outputs; out_valid=1; go to OUTPUT.
- sat(): clamp to [−2^(FXP_WIDTH-1), 2^(FXP_WIDTH-1)−1].
- Latency: out_valid is high STATE_DIM+1 edges after the accept edge (5 with defaults).
- OUTPUT:
  - Outputs held stable while out_valid & !out_ready.
  - On out_ready: out_valid=0 at that edge; go to WAIT_FB.
- WAIT_FB:
  - fb_ready=1.
  - On fb_valid: x[] = state_fb_in, P[] = cov_fb_in; go to IDLE.
  - fb_ready=0 on the same edge; meas_ready=1 from the next cycle.
- meas_ready=0 and fb_ready=0 in every state other than those above.
- fb_valid outside WAIT_FB is ignored and dropped; meas_valid outside IDLE is not accepted.
- Output bus registers keep their last values after the handshake; only out_valid deasserts.
- Reset asserted mid-operation: immediate return to reset values; any in-flight measurement is discarded.

Optional Feature:
- Macro: KALMAN_INNOV_GATE_EN.
- Defined:
  - After sat, innovation is clamped to [−GATE_Q, +GATE_Q].
  - gate_hit=1 with the bundle when clamping occurred, else 0; it clears when out_valid drops.
- Undefined:
  - No clamp beyond sat; gate_hit tied to 0; no gate logic synthesized.

Test Plan:
- Reset, fb held low, meas 0x0200 with out_ready=1:
  - out_valid exactly 5 cycles after accept.
  - innovation_out=0x0200; state_vector_out=0; each cov element 0x0110; meas_count=1.
- Backpressure, out_ready low 3 cycles after out_valid:
  - All outputs stable; meas_ready=0 and fb_ready=0 throughout.
  - After handshake, fb_ready=1 the next cycle.
- Feedback x=[0x0100,0x0080,0,0], P all 0x0100, then meas 0x0100:
  - xp[0]=0x0180, xp[1]=0x0080.
  - innovation_out=0xFF80; cov elements 0x0110.
- Saturation, x[0]=x[1]=0x7F00, P=0x7FF8, meas 0x8000:
  - xp[0]=0x7FFF; cov=0x7FFF; innovation_out=0x8000 (without macro).
- rst_n pulsed in PREDICT (k=2):
  - All outputs at reset values; meas_ready=1; next measurement 0x0040 gives innovation 0x0040.
- With KALMAN_INNOV_GATE_EN, state zero, meas 0x0800:
  - innovation_out=0x0400, gate_hit=1.
  - Next measurement 0x0100 (state zero) gives gate_hit=0.
